// File: rtl/rb_rr_arbiter.sv
// Round-robin burst arbiter: shares one valid/ready sink among N ring-buffer outputs,
// holding each grant for up to a configurable number of handshakes.
module rb_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BW-1:0]   cfg_burst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  input  logic            o_ready,
  output logic [N-1:0]    grant_oh,
  output logic            busy
);

  localparam int PW = $clog2(N);
  localparam int SW = PW + 1;
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [PW-1:0] r_gidx, w_gidx_nxt;
  logic [PW-1:0] w_pick;
  logic [N-1:0]  r_grant_oh, w_grant_nxt;
  logic [BW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_lim, w_lim_nxt;
  logic [BW-1:0] w_eff;
  logic [SW-1:0] w_scan;
  logic          w_any;
  logic          w_gvalid;
  logic          w_beat;
  logic          w_last;

  always_comb begin
    w_eff = cfg_burst;
    if (cfg_burst == '0 || cfg_burst > MAXB) w_eff = MAXB;
  end

  // Rotating priority scan: first valid requester at or after r_ptr, modulo N.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_scan = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan = {1'b0, r_ptr} + SW'(k);
      if (w_scan >= SW'(N)) w_scan = w_scan - SW'(N);
      if (!w_any && req_valid[w_scan[PW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_scan[PW-1:0];
      end
    end
  end

  // Datapath is pure muxing; req_ready depends only on o_ready, never on req_valid.
  always_comb begin
    w_gvalid  = req_valid[r_gidx];
    o_valid   = 1'b0;
    o_data    = '0;
    req_ready = '0;
    if (r_state == GRANT && !rst) begin
      o_valid   = w_gvalid;
      o_data    = req_data[r_gidx*DW +: DW];
      req_ready = o_ready ? r_grant_oh : '0;
    end
  end

  assign w_beat = o_valid & o_ready;
  assign w_last = w_beat && ((r_cnt + 1'b1) == r_lim);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_grant_nxt = r_grant_oh;
    w_cnt_nxt   = r_cnt;
    w_lim_nxt   = r_lim;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_pick;
          w_cnt_nxt   = '0;
          w_lim_nxt   = w_eff;
        end
      end
      GRANT: begin
        if (w_last || !w_gvalid) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + 1'b1;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_grant_oh <= '0;
      r_cnt      <= '0;
      r_lim      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_grant_oh <= w_grant_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lim      <= w_lim_nxt;
    end
  end

  assign grant_oh = r_grant_oh;
  assign busy     = (r_state == GRANT) && !rst;

endmodule

// File: tb/tb_rb_rr_arbiter.sv
// Directed bench for rb_rr_arbiter: ring-buffer sources modelled as FIFOs popped on handshake.
module tb_rb_rr_arbiter;
  localparam int N = 4, DW = 8, MAX_BURST = 16, BW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   cfg_burst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            o_ready;
  logic [N-1:0]    grant_oh;
  logic            busy;

  always #5 clk = ~clk;

  rb_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST), .BW(BW)) dut (
    .clk(clk), .rst(rst), .cfg_burst(cfg_burst), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .o_valid(o_valid),
    .o_data(o_data), .o_ready(o_ready), .grant_oh(grant_oh), .busy(busy)
  );

  logic [DW-1:0] mem [N][64];
  int unsigned   head [N];
  int unsigned   tail [N];
  int            passed = 0;
  int            total  = 0;

  logic          s_valid, s_busy;
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_rdy, s_grant;

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (head[i] < tail[i]);
      req_data[i*DW +: DW]  = (head[i] < tail[i]) ? mem[i][head[i]] : '0;
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d);
    mem[i][tail[i]] = d;
    tail[i]++;
  endtask

  // Sample at negedge, pop sources on the handshake seen there, update sources after the edge.
  task automatic cyc();
    @(negedge clk);
    s_valid = o_valid; s_data = o_data; s_rdy = req_ready;
    s_grant = grant_oh; s_busy = busy;
    @(posedge clk);
    for (int i = 0; i < N; i++) if (s_rdy[i] && req_valid[i]) head[i]++;
    #1;
    drive_srcs();
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    drive_srcs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_srcs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; o_ready = 1'b1; cfg_burst = 5'd2;
    clear_srcs();
    for (int i = 0; i < N; i++) push(i, 8'(16 * (i + 1)));
    drive_srcs();
    for (int c = 0; c < 2; c++) begin
      cyc();
      total++; if (s_valid !== 1'b0) $display("FAIL reset_o_valid c%0d got %b exp 0", c, s_valid); else passed++;
      total++; if (s_rdy !== 4'b0000) $display("FAIL reset_req_ready c%0d got %b exp 0000", c, s_rdy); else passed++;
      total++; if (s_grant !== 4'b0000) $display("FAIL reset_grant c%0d got %b exp 0000", c, s_grant); else passed++;
      total++; if (s_busy !== 1'b0) $display("FAIL reset_busy c%0d got %b exp 0", c, s_busy); else passed++;
    end
    rst = 1'b0;
    cyc();
    total++; if (s_grant !== 4'b0000 || s_valid !== 1'b0) $display("FAIL reset_idle_bubble grant %b valid %b exp 0000/0", s_grant, s_valid); else passed++;
    cyc();
    total++; if (s_grant !== 4'b0001) $display("FAIL reset_first_grant got %b exp 0001", s_grant); else passed++;
    total++; if (s_data !== 8'h10) $display("FAIL reset_first_data got %h exp 10", s_data); else passed++;
  endtask

  task automatic test_round_robin();
    int ph, rd, g, k;
    logic [N-1:0] eg;
    logic ev;
    logic [DW-1:0] ed;
    do_reset();
    cfg_burst = 5'd2; o_ready = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) push(i, 8'(16 * (i + 1) + j));
    drive_srcs();
    for (int c = 0; c < 15; c++) begin
      ph = c % 3; rd = c / 3;
      if (ph == 0) begin
        eg = '0; ev = 1'b0; ed = '0;
      end else begin
        g = rd % 4; k = (rd / 4) * 2 + ph - 1;
        eg = 4'(1 << g); ev = 1'b1; ed = 8'(16 * (g + 1) + k);
      end
      cyc();
      total++; if (s_grant !== eg) $display("FAIL rr_grant c%0d got %b exp %b", c, s_grant, eg); else passed++;
      total++; if (s_valid !== ev) $display("FAIL rr_valid c%0d got %b exp %b", c, s_valid, ev); else passed++;
      total++; if (s_data !== ed) $display("FAIL rr_data c%0d got %h exp %h", c, s_data, ed); else passed++;
      total++; if (s_rdy !== eg) $display("FAIL rr_ready c%0d got %b exp %b", c, s_rdy, eg); else passed++;
    end
  endtask

  task automatic test_early_exit();
    do_reset();
    cfg_burst = 5'd8; o_ready = 1'b1;
    push(2, 8'h31); push(2, 8'h32); push(2, 8'h33);
    drive_srcs();
    cyc();
    total++; if (s_grant !== 4'b0000) $display("FAIL ee_bubble got %b exp 0000", s_grant); else passed++;
    for (int b = 0; b < 3; b++) begin
      cyc();
      total++; if (s_grant !== 4'b0100 || s_valid !== 1'b1) $display("FAIL ee_grant b%0d grant %b valid %b exp 0100/1", b, s_grant, s_valid); else passed++;
      total++; if (s_data !== 8'(8'h31 + b)) $display("FAIL ee_data b%0d got %h exp %h", b, s_data, 8'(8'h31 + b)); else passed++;
    end
    cyc();
    total++; if (s_busy !== 1'b1 || s_valid !== 1'b0) $display("FAIL ee_empty busy %b valid %b exp 1/0", s_busy, s_valid); else passed++;
    push(2, 8'h34); drive_srcs();
    cyc();
    total++; if (s_grant !== 4'b0000) $display("FAIL ee_rebubble got %b exp 0000", s_grant); else passed++;
    cyc();
    total++; if (s_grant !== 4'b0100 || s_data !== 8'h34) $display("FAIL ee_regrant grant %b data %h exp 0100/34", s_grant, s_data); else passed++;
    cyc();
    total++; if (s_valid !== 1'b0 || s_busy !== 1'b1) $display("FAIL ee_empty2 valid %b busy %b exp 0/1", s_valid, s_busy); else passed++;
    // ptr now 3: scan order 3,0,1,2 picks req1 ahead of req2
    push(1, 8'h41); push(2, 8'h35); drive_srcs();
    cyc();
    total++; if (s_grant !== 4'b0000) $display("FAIL ee_ptr_bubble got %b exp 0000", s_grant); else passed++;
    cyc();
    total++; if (s_grant !== 4'b0010) $display("FAIL ee_ptr_grant got %b exp 0010", s_grant); else passed++;
  endtask

  task automatic test_backpressure();
    int beats;
    do_reset();
    cfg_burst = 5'd4; beats = 0;
    for (int j = 0; j < 6; j++) push(0, 8'(8'h50 + j));
    drive_srcs();
    for (int c = 0; c < 10; c++) begin
      o_ready = (c % 2 == 0);
      cyc();
      if (c >= 1 && c <= 8) begin
        total++; if (s_busy !== 1'b1 || s_valid !== 1'b1) $display("FAIL bp_busy c%0d busy %b valid %b exp 1/1", c, s_busy, s_valid); else passed++;
        total++; if (s_rdy !== {3'b000, o_ready}) $display("FAIL bp_ready c%0d got %b exp %b", c, s_rdy, {3'b000, o_ready}); else passed++;
        total++; if (s_data !== 8'(8'h50 + beats)) $display("FAIL bp_data c%0d got %h exp %h", c, s_data, 8'(8'h50 + beats)); else passed++;
      end else begin
        total++; if (s_busy !== 1'b0) $display("FAIL bp_idle c%0d busy %b exp 0", c, s_busy); else passed++;
      end
      if (s_valid && o_ready) beats++;
    end
    total++; if (beats !== 4) $display("FAIL bp_beats got %0d exp 4", beats); else passed++;
  endtask

  task automatic test_config();
    logic [BW-1:0] cfg_a [3];
    logic [BW-1:0] cfg_b [3];
    int            exp_n [3];
    int            beats;
    cfg_a = '{5'd0, 5'd20, 5'd4};
    cfg_b = '{5'd0, 5'd20, 5'd1};
    exp_n = '{16, 16, 4};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      cfg_burst = cfg_a[t]; o_ready = 1'b1; beats = 0;
      for (int j = 0; j < 20; j++) push(0, 8'(j + 1));
      drive_srcs();
      for (int c = 0; c <= exp_n[t] + 1; c++) begin
        if (c == 2) cfg_burst = cfg_b[t];
        cyc();
        if (s_valid && o_ready) beats++;
      end
      total++; if (beats !== exp_n[t]) $display("FAIL cfg_beats t%0d got %0d exp %0d", t, beats, exp_n[t]); else passed++;
      total++; if (s_grant !== 4'b0000) $display("FAIL cfg_exit t%0d grant %b exp 0000", t, s_grant); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cfg_burst = 5'd4; o_ready = 1'b1;
    push(1, 8'h61); push(1, 8'h62); push(1, 8'h63);
    drive_srcs();
    cyc();
    cyc();
    total++; if (s_grant !== 4'b0010 || s_data !== 8'h61) $display("FAIL mr_first grant %b data %h exp 0010/61", s_grant, s_data); else passed++;
    rst = 1'b1;
    push(0, 8'h71); push(0, 8'h72); drive_srcs();
    cyc();
    total++; if (s_valid !== 1'b0 || s_rdy !== 4'b0000) $display("FAIL mr_rst_cycle valid %b ready %b exp 0/0000", s_valid, s_rdy); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL mr_rst_busy got %b exp 0", s_busy); else passed++;
    rst = 1'b0;
    cyc();
    total++; if (s_grant !== 4'b0000) $display("FAIL mr_after_grant got %b exp 0000", s_grant); else passed++;
    total++; if (head[1] !== 1) $display("FAIL mr_req1_pops got %0d exp 1", head[1]); else passed++;
    cyc();
    total++; if (s_grant !== 4'b0001 || s_data !== 8'h71) $display("FAIL mr_regrant grant %b data %h exp 0001/71", s_grant, s_data); else passed++;
  endtask

  initial begin
    rst = 1'b1; o_ready = 1'b0; cfg_burst = '0;
    req_valid = '0; req_data = '0;
    test_reset();
    test_round_robin();
    test_early_exit();
    test_backpressure();
    test_config();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
